// File: rtl/lte_pss_mapper.sv
// lte_pss_mapper: captures one 62-sample LTE PSS sequence d(0..61) from an
// AXI-Stream input and emits a full FFT_SIZE-bin IFFT input symbol with the
// sequence placed around DC (bins 1..31 and FFT_SIZE-31..FFT_SIZE-1).
// Optional feature: define LTE_PSS_MAPPER_ERR_CNT_EN to add the err_cnt port,
// a saturating 8-bit count of sequence length errors.
module lte_pss_mapper #(
    parameter int FFT_SIZE = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
`ifdef LTE_PSS_MAPPER_ERR_CNT_EN
    output logic [7:0]  err_cnt,
`endif
    output logic        err_len
);

    localparam int BIN_W = $clog2(FFT_SIZE);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    logic [1:0]       state;
    logic [5:0]       cnt;
    logic [BIN_W-1:0] bin;
    logic             err_q;
    logic             s_fire;
    logic             m_fire;
    logic [5:0]       rd_idx;
    logic             in_band;

    // Only 62 entries are ever written; the two spare entries let a 6-bit
    // index address the array without a range hole.
    logic [31:0]      seq_buf [0:63];

    // Outputs are forced idle while rst_n is low, independent of state.
    assign s_axis_tready = rst_n && (state != ST_EMIT);
    assign m_axis_tvalid = rst_n && (state == ST_EMIT);
    assign m_axis_tlast  = m_axis_tvalid && (bin == BIN_W'(FFT_SIZE - 1));
    assign err_len       = rst_n && err_q;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;

    // Sequence control: capture, drain overlong input, emit one symbol.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_FILL;
            cnt   <= '0;
            bin   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (s_fire) begin
                        if (s_axis_tlast) begin
                            cnt <= '0;
                            if (cnt == 6'd61) begin
                                state <= ST_EMIT;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else if (cnt == 6'd61) begin
                            cnt   <= '0;
                            err_q <= 1'b1;
                            state <= ST_DRAIN;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_fire && s_axis_tlast) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (m_fire) begin
                        if (bin == BIN_W'(FFT_SIZE - 1)) begin
                            bin   <= '0;
                            state <= ST_FILL;
                        end else begin
                            bin <= bin + BIN_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    // Sample buffer write; data storage carries no reset.
    always_ff @(posedge clk) begin
        if (s_fire && (state == ST_FILL)) begin
            seq_buf[cnt] <= s_axis_tdata;
        end
    end

    // Bin-to-sample mapping. FFT_SIZE is a multiple of 64, so the low six bits
    // of bin suffice: bins 1..31 map to bin+30, and the upper band starting at
    // FFT_SIZE-31 (= 33 mod 64) maps to bin-33.
    always_comb begin
        in_band = 1'b0;
        rd_idx  = '0;
        if ((bin != '0) && (bin <= BIN_W'(31))) begin
            in_band = 1'b1;
            rd_idx  = bin[5:0] + 6'd30;
        end else if (bin >= BIN_W'(FFT_SIZE - 31)) begin
            in_band = 1'b1;
            rd_idx  = bin[5:0] - 6'd33;
        end
    end

    assign m_axis_tdata = (m_axis_tvalid && in_band) ? seq_buf[rd_idx] : 32'd0;

`ifdef LTE_PSS_MAPPER_ERR_CNT_EN
    // Saturating count of length-error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (err_q && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lte_pss_mapper.sv
// Testbench for lte_pss_mapper: scoreboard of expected IFFT bins built from
// the driven sequence, checked as the mapper emits them.
// Define LTE_PSS_MAPPER_ERR_CNT_EN to also exercise the err_cnt port.
module tb_lte_pss_mapper;

    parameter int FFT_SIZE = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        err_len;
`ifdef LTE_PSS_MAPPER_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    bit stall_mode = 1'b0;

    logic [32:0] exp_q [$];
    logic [31:0] stim [0:79];
    logic [31:0] cap  [FFT_SIZE];

    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    lte_pss_mapper #(.FFT_SIZE(FFT_SIZE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
`ifdef LTE_PSS_MAPPER_ERR_CNT_EN
        .err_cnt       (err_cnt),
`endif
        .err_len       (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Downstream ready: steady high, or toggling every cycle in stall mode.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = stall_mode ? ~m_axis_tready : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each transfer, checks stability
    // while stalled, and counts err_len pulses.
    initial begin
        int idx;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (err_len) err_seen++;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_vld", {31'b0, m_axis_tvalid}, 32'd1);
                    check("stall_data", m_axis_tdata, prev_data);
                    check("stall_last", {31'b0, m_axis_tlast}, {31'b0, prev_last});
                end
                if (m_axis_tvalid && exp_q.size() == 0) begin
                    check("spurious_vld", {31'b0, m_axis_tvalid}, 32'd0);
                end else if (m_axis_tvalid && m_axis_tready) begin
                    idx = FFT_SIZE - exp_q.size();
                    e = exp_q.pop_front();
                    cap[idx] = m_axis_tdata;
                    check($sformatf("bin%0d_data", idx), m_axis_tdata, e[31:0]);
                    check($sformatf("bin%0d_last", idx), {31'b0, m_axis_tlast}, {31'b0, e[32]});
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    task automatic fill_pss();
        for (int n = 0; n < 80; n++) begin
            stim[n] = {n[15:0], 16'(-n)};
        end
    endtask

    task automatic fill_rand();
        for (int n = 0; n < 80; n++) begin
            stim[n] = $urandom;
        end
    endtask

    // Expected symbol from stim[0..61]: d(0..30) at the top bins, d(31..61) at bins 1..31.
    task automatic push_symbol();
        logic [31:0] sym [FFT_SIZE];
        for (int b = 0; b < FFT_SIZE; b++) sym[b] = 32'd0;
        for (int n = 0; n <= 30; n++) sym[FFT_SIZE - 31 + n] = stim[n];
        for (int n = 31; n <= 61; n++) sym[n - 30] = stim[n];
        for (int b = 0; b < FFT_SIZE; b++) exp_q.push_back({(b == FFT_SIZE - 1), sym[b]});
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        int  t = 0;
        bit  done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        while (!done) begin
            @(negedge clk);
            if (s_axis_tready) begin
                done = 1'b1;
            end else if (t > 50) begin
                check("in_timeout", {31'b0, s_axis_tready}, 32'd1);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            t++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_seq(input int len);
        if (len >= 62) push_symbol();
        for (int k = 0; k < len; k++) begin
            send_beat(stim[k], (k == len - 1));
            if ((k == 61 && len > 62) || (len < 62 && k == len - 1)) begin
                @(negedge clk);
                check("err_len_pulse", {31'b0, err_len}, 32'd1);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_symbol(input bit stalled);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 4 * FFT_SIZE + 20) begin
            @(negedge clk);
            #1;
            if (cyc == 0) check("latency_vld", {31'b0, m_axis_tvalid}, 32'd1);
            cyc++;
        end
        check("sym_drained", 32'(exp_q.size()), 32'd0);
        if (!stalled) check("emit_cycles", 32'(cyc), 32'(FFT_SIZE));
        @(negedge clk);
        check("ret_fill_rdy", {31'b0, s_axis_tready}, 32'd1);
        check("idle_vld", {31'b0, m_axis_tvalid}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic spot_checks();
        check("cap_bin0", cap[0], 32'd0);
        check("cap_bin1", cap[1], {16'd31, 16'hFFE1});
        check("cap_bin31", cap[31], {16'd61, 16'hFFC3});
        check("cap_bin32", cap[32], 32'd0);
        check("cap_binlo_end", cap[FFT_SIZE - 32], 32'd0);
        check("cap_d0", cap[FFT_SIZE - 31], 32'd0);
        check("cap_d1", cap[FFT_SIZE - 30], {16'd1, 16'hFFFF});
        check("cap_d30", cap[FFT_SIZE - 1], {16'd30, 16'hFFE2});
    endtask

    initial begin
        int e0;
        int t;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_s_rdy", {31'b0, s_axis_tready}, 32'd0);
        check("rst_m_vld", {31'b0, m_axis_tvalid}, 32'd0);
        check("rst_m_last", {31'b0, m_axis_tlast}, 32'd0);
        check("rst_m_data", m_axis_tdata, 32'd0);
        check("rst_err", {31'b0, err_len}, 32'd0);
`ifdef LTE_PSS_MAPPER_ERR_CNT_EN
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", {31'b0, s_axis_tready}, 32'd1);
        @(posedge clk);
        #1;

        // Ramp sequence, no backpressure
        fill_pss();
        send_seq(62);
        wait_symbol(1'b0);
        spot_checks();

        // Same sequence with alternating downstream stalls
        for (int b = 0; b < FFT_SIZE; b++) cap[b] = 32'hDEADBEEF;
        stall_mode = 1'b1;
        send_seq(62);
        wait_symbol(1'b1);
        stall_mode = 1'b0;
        @(posedge clk);
        #1;
        spot_checks();

        // Short sequence (tlast on beat 40), then a normal one
        e0 = err_seen;
        fill_rand();
        send_seq(41);
        repeat (10) @(posedge clk);
        #1;
        check("short_err_count", 32'(err_seen - e0), 32'd1);
        fill_rand();
        send_seq(62);
        wait_symbol(1'b0);

        // Long sequence: 65 beats, tlast on beat 64
        e0 = err_seen;
        fill_rand();
        send_seq(65);
        wait_symbol(1'b0);
        check("long_err_count", 32'(err_seen - e0), 32'd1);

        // Reset while bin 50 is presented
        fill_pss();
        send_seq(62);
        t = 0;
        while (exp_q.size() > FFT_SIZE - 50 && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reach_bin50", 32'(exp_q.size()), 32'(FFT_SIZE - 50));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_vld", {31'b0, m_axis_tvalid}, 32'd0);
        check("midrst_rdy", {31'b0, s_axis_tready}, 32'd0);
        check("midrst_data", m_axis_tdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rel_rdy", {31'b0, s_axis_tready}, 32'd1);
        check("midrst_rel_vld", {31'b0, m_axis_tvalid}, 32'd0);
        repeat (2 * FFT_SIZE) @(negedge clk);
        check("no_resume_vld", {31'b0, m_axis_tvalid}, 32'd0);
        @(posedge clk);
        #1;
        fill_rand();
        send_seq(62);
        wait_symbol(1'b0);

`ifdef LTE_PSS_MAPPER_ERR_CNT_EN
        // Saturation of the error counter
        e0 = err_seen;
        fill_rand();
        for (int i = 0; i < 300; i++) send_seq(3);
        repeat (3) @(posedge clk);
        #1;
        check("sat_err_seen", 32'(err_seen - e0), 32'd300);
        check("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lte_pss_mapper.md
LTE_PSS_MAPPER -- requirements
Module: lte_pss_mapper

Interface
REQ-001 Parameter: FFT_SIZE, default 128, IFFT length in bins; legal values 128, 256, 512, 1024, 2048.
REQ-002 Port: clk  input  1  sole clock; all logic rising-edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: s_axis_tdata  input  32  PSS sample d(n); [31:16] Q, [15:0] I, signed 16-bit each.
REQ-005 Port: s_axis_tvalid  input  1  upstream sample valid.
REQ-006 Port: s_axis_tready  output  1  mapper accepts sample.
REQ-007 Port: s_axis_tlast  input  1  marks d(61), last sample of a PSS sequence.
REQ-008 Port: m_axis_tdata  output  32  IFFT-bin sample, same I/Q packing as input.
REQ-009 Port: m_axis_tvalid  output  1  output sample valid.
REQ-010 Port: m_axis_tready  input  1  downstream IFFT accepts sample.
REQ-011 Port: m_axis_tlast  output  1  marks bin FFT_SIZE-1.
REQ-012 Port: err_len  output  1  one-cycle pulse on input sequence length error.

Function
REQ-013 Handshake: beat transfers when tvalid and tready are both high on a rising edge; mapper never drops an accepted beat.
REQ-014 States: FILL (capture), DRAIN (discard to tlast), EMIT (output a symbol).
REQ-015 FILL: s_axis_tready=1; beat k (k=0..61) written to buffer entry k; m_axis_tvalid=0.
REQ-016 FILL, beat 61 with tlast=1: go to EMIT next cycle.
REQ-017 FILL, tlast=1 on beat k<61: discard partial sequence, pulse err_len, reset count to 0, stay in FILL.
REQ-018 FILL, beat 61 with tlast=0: pulse err_len, go to DRAIN; buffered 62 samples kept.
REQ-019 DRAIN: s_axis_tready=1, accepted beats discarded; beat with tlast=1 moves to EMIT.
REQ-020 EMIT: s_axis_tready=0; emit exactly FFT_SIZE beats, bin b = 0..FFT_SIZE-1 in order.
REQ-021 Mapping: bin 0 (DC) = 0; bins 1..31 = d(31..61); bins FFT_SIZE-31..FFT_SIZE-1 = d(0..30); all other bins = 0.
REQ-022 Latency: m_axis_tvalid asserts in the cycle after the accepted terminating tlast beat; no bubbles while m_axis_tready=1.
REQ-023 Backpressure: with m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tlast held stable; tvalid not withdrawn.
REQ-024 m_axis_tlast=1 only on bin FFT_SIZE-1; after that beat transfers, return to FILL with s_axis_tready=1 next cycle.
REQ-025 Sample values pass bit-exact; no scaling, rounding or sign change.
REQ-026 err_len and a simultaneous valid tlast cannot both occur; err_len never asserted in EMIT.

Reset
REQ-027 While rst_n=0: state FILL, count 0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, err_len=0.
REQ-028 s_axis_tready=1 in first cycle after rst_n returns high.
REQ-029 Reset mid-EMIT or mid-FILL aborts the symbol; no further output beats until a new full sequence; buffer contents need not be cleared.

Configuration
REQ-030 Macro LTE_PSS_MAPPER_ERR_CNT_EN defined: extra port err_cnt output 8, saturating count of err_len pulses, reset to 0, holds at 255.
REQ-031 Macro undefined: err_cnt port and counter absent; all other behaviour identical.

Verification
REQ-032 d(n)={Q=n,I=-n} for n=0..61, tlast on 61, m_axis_tready=1 -> 128 beats: bin0=0, bin1={31,-31}, bin31={61,-61}, bin97={0,0}, bin127={30,-30}, bins 32..96 zero, tlast only on bin127.
REQ-033 m_axis_tready toggled 1-0-1 every cycle during EMIT -> 128 transfers, each beat stable while stalled, sequence identical to REQ-032.
REQ-034 tlast on beat 40 -> err_len pulse, no output; following correct 62-beat sequence -> normal 128-beat symbol.
REQ-035 65 beats, tlast on beat 64 -> err_len pulse at beat 61, beats 62-64 discarded, output maps first 62 samples.
REQ-036 rst_n low for 1 cycle at output bin 50 -> m_axis_tvalid=0 next cycle, s_axis_tready=1 one cycle after release, no resumed output.
REQ-037 FFT_SIZE=256 -> d(0) at bin 225, d(30) at bin 255, bins 32..224 zero; with LTE_PSS_MAPPER_ERR_CNT_EN, 300 short sequences -> err_cnt=255.
